fpu_unpack_norm: RTL and testbench

Unpacker and classifier for IEEE 754 single-precision operands at the FPU input boundary. It is the inverse of the FPU output packer. It accepts a 32-bit float over a valid/ready handshake, splits it into sign, unbiased exponent and a 24-bit mantissa with the hidden bit made explicit, and classifies the operand. Subnormals are normalized iteratively, one bit per cycle, so downstream arithmetic sees a leading 1 for every finite non-zero operand.

---
 rtl/fpu_unpack_norm.sv | 148 ++++++++++++++
 tb/tb_fpu_unpack_norm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_unpack_norm.sv
// fpu_unpack_norm: unpacks an IEEE 754 single into sign / unbiased exponent /
// explicit-integer-bit mantissa, classifies it, and normalizes subnormals
// one bit per cycle so downstream logic sees a leading 1 on finite non-zeros.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   in_data[31:0]       IEEE 754 single-precision operand
//   out_valid/out_ready result handshake (out_valid high only in HOLD)
//   out_sign            operand sign
//   out_exp[9:0]        signed unbiased exponent
//   out_mant[23:0]      mantissa, bit 23 is the integer bit
//   out_is_*            class flags, registered with the result
module fpu_unpack_norm #(
   parameter bit NORMALIZE_SUB = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sign,
   output logic [9:0]  out_exp,
   output logic [23:0] out_mant,
   output logic        out_is_zero,
   output logic        out_is_sub,
   output logic        out_is_inf,
   output logic        out_is_nan,
   output logic        out_is_snan
);

   localparam int unsigned EXP_W  = 10;
   localparam int unsigned MANT_W = 24;
   localparam int unsigned FRAC_W = 23;

   localparam logic [EXP_W-1:0] EXP_BIAS = EXP_W'(127);
   localparam logic [EXP_W-1:0] EXP_SUB  = EXP_W'(-126);
   localparam logic [EXP_W-1:0] EXP_SPEC = EXP_W'(128);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t state;

   // Field decode of the incoming operand
   logic [7:0]        e_in;
   logic [FRAC_W-1:0] frac_in;
   logic              e_zero;
   logic              e_max;
   logic              frac_nz;

   assign e_in    = in_data[30:23];
   assign frac_in = in_data[FRAC_W-1:0];
   assign e_zero  = (e_in == 8'd0);
   assign e_max   = (&e_in);
   assign frac_nz = (|frac_in);

   // Handshake FSM with registered result and class flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_sign    <= 1'b0;
         out_exp     <= '0;
         out_mant    <= '0;
         out_is_zero <= 1'b0;
         out_is_sub  <= 1'b0;
         out_is_inf  <= 1'b0;
         out_is_nan  <= 1'b0;
         out_is_snan <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  out_sign    <= in_data[31];
                  out_is_zero <= 1'b0;
                  out_is_sub  <= 1'b0;
                  out_is_inf  <= 1'b0;
                  out_is_nan  <= 1'b0;
                  out_is_snan <= 1'b0;
                  state       <= ST_HOLD;
                  in_ready    <= 1'b0;
                  out_valid   <= 1'b1;
                  if (e_max) begin
                     out_exp <= EXP_SPEC;
                     if (frac_nz) begin
                        out_mant    <= {1'b1, frac_in};
                        out_is_nan  <= 1'b1;
                        out_is_snan <= ~frac_in[FRAC_W-1];
                     end else begin
                        out_mant   <= {1'b1, {FRAC_W{1'b0}}};
                        out_is_inf <= 1'b1;
                     end
                  end else if (e_zero) begin
                     if (frac_nz) begin
                        out_exp    <= EXP_SUB;
                        out_mant   <= {1'b0, frac_in};
                        out_is_sub <= 1'b1;
                        if (NORMALIZE_SUB) begin
                           state     <= ST_NORM;
                           out_valid <= 1'b0;
                        end
                     end else begin
                        out_exp     <= '0;
                        out_mant    <= '0;
                        out_is_zero <= 1'b1;
                     end
                  end else begin
                     out_exp  <= {2'b00, e_in} - EXP_BIAS;
                     out_mant <= {1'b1, frac_in};
                  end
               end
            end

            // One shift per cycle; leave as soon as the shifted value has its MSB set
            ST_NORM: begin
               out_mant <= {out_mant[MANT_W-2:0], 1'b0};
               out_exp  <= out_exp - EXP_W'(1);
               if (out_mant[MANT_W-2]) begin
                  state     <= ST_HOLD;
                  out_valid <= 1'b1;
               end
            end

            ST_HOLD: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end

            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_unpack_norm.sv
// Directed self-checking bench for fpu_unpack_norm (normalizing instance plus a
// non-normalizing instance for the NORMALIZE_SUB=0 subnormal path).
`timescale 1ns/1ps
module tb_fpu_unpack_norm;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [9:0]  out_exp;
   logic [23:0] out_mant;
   logic        out_is_zero, out_is_sub, out_is_inf, out_is_nan, out_is_snan;

   logic        n0_in_valid;
   logic        n0_in_ready;
   logic [31:0] n0_in_data;
   logic        n0_out_valid;
   logic        n0_out_ready;
   logic        n0_out_sign;
   logic [9:0]  n0_out_exp;
   logic [23:0] n0_out_mant;
   logic        n0_zero, n0_sub, n0_inf, n0_nan, n0_snan;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   logic [4:0]  flags;
   logic [23:0] held_mant;
   logic [9:0]  held_exp;
   int stale;

   assign flags = {out_is_zero, out_is_sub, out_is_inf, out_is_nan, out_is_snan};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   fpu_unpack_norm #(.NORMALIZE_SUB(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
      .out_is_zero(out_is_zero), .out_is_sub(out_is_sub), .out_is_inf(out_is_inf),
      .out_is_nan(out_is_nan), .out_is_snan(out_is_snan)
   );

   fpu_unpack_norm #(.NORMALIZE_SUB(1'b0)) dut_n0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(n0_in_valid), .in_ready(n0_in_ready), .in_data(n0_in_data),
      .out_valid(n0_out_valid), .out_ready(n0_out_ready),
      .out_sign(n0_out_sign), .out_exp(n0_out_exp), .out_mant(n0_out_mant),
      .out_is_zero(n0_zero), .out_is_sub(n0_sub), .out_is_inf(n0_inf),
      .out_is_nan(n0_nan), .out_is_snan(n0_snan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operand for exactly one rising edge; sample point is #1 after it
   task automatic accept(input logic [31:0] d);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Extra edges after the accept edge until out_valid, bounded
   task automatic wait_valid(output int c);
      c = 0;
      while (!out_valid && c < 40) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (!out_valid) begin
         n_err++;
         $error("FAIL wait_valid: out_valid not seen within %0d cycles", c);
      end
   endtask

   task automatic xfer();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      n0_in_valid = 1'b0; n0_in_data = '0; n0_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_exp", out_exp, 10'h000);
      chk("rst_mant", out_mant, 24'h000000);
      chk("rst_sign_flags", {out_sign, flags}, 6'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1.5
      accept(32'h3FC0_0000);
      wait_valid(cyc);
      chk("n15_lat", cyc, 0);
      chk("n15_sign", out_sign, 1'b0);
      chk("n15_exp", out_exp, 10'h000);
      chk("n15_mant", out_mant, 24'hC00000);
      chk("n15_flags", flags, 5'b00000);
      chk("n15_in_ready", in_ready, 1'b0);
      xfer();
      chk("n15_post_ready", in_ready, 1'b1);
      chk("n15_post_valid", out_valid, 1'b0);

      // smallest subnormal
      accept(32'h0000_0001);
      chk("sub1_norm_busy", out_valid, 1'b0);
      wait_valid(cyc);
      chk("sub1_lat", cyc, 23);
      chk("sub1_exp", out_exp, 10'h36B);
      chk("sub1_mant", out_mant, 24'h800000);
      chk("sub1_flags", flags, 5'b01000);
      xfer();

      // one-step subnormal, out_ready already high during NORM
      @(negedge clk);
      out_ready = 1'b1;
      accept(32'h0040_0000);
      out_ready = 1'b1;
      chk("sub4_norm_valid", out_valid, 1'b0);
      wait_valid(cyc);
      chk("sub4_lat", cyc, 1);
      chk("sub4_exp", out_exp, 10'h381);
      chk("sub4_mant", out_mant, 24'h800000);
      chk("sub4_flags", flags, 5'b01000);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("sub4_xfer_ready", in_ready, 1'b1);

      // specials
      accept(32'h8000_0000);
      wait_valid(cyc);
      chk("nzero_sign", out_sign, 1'b1);
      chk("nzero_exp_mant", {out_exp, out_mant}, 34'h0);
      chk("nzero_flags", flags, 5'b10000);
      xfer();

      accept(32'h7F80_0000);
      wait_valid(cyc);
      chk("inf_lat", cyc, 0);
      chk("inf_exp", out_exp, 10'd128);
      chk("inf_mant", out_mant, 24'h800000);
      chk("inf_flags", flags, 5'b00100);
      xfer();

      accept(32'h7FC0_0000);
      wait_valid(cyc);
      chk("qnan_mant", out_mant, 24'hC00000);
      chk("qnan_flags", flags, 5'b00010);
      xfer();

      accept(32'h7F80_0001);
      wait_valid(cyc);
      chk("snan_exp", out_exp, 10'd128);
      chk("snan_mant", out_mant, 24'h800001);
      chk("snan_flags", flags, 5'b00011);
      xfer();

      // non-normalizing instance: subnormal passes straight through
      @(negedge clk);
      n0_in_valid = 1'b1;
      n0_in_data  = 32'h0000_0001;
      @(posedge clk);
      #1;
      n0_in_valid = 1'b0;
      chk("n0_valid", n0_out_valid, 1'b1);
      chk("n0_exp", n0_out_exp, 10'h382);
      chk("n0_mant", n0_out_mant, 24'h000001);
      chk("n0_flags", {n0_zero, n0_sub, n0_inf, n0_nan, n0_snan}, 5'b01000);

      // backpressure: pi held for 5 cycles, a stray operand is ignored
      accept(32'h4049_0FDB);
      wait_valid(cyc);
      held_mant = 24'hC90FDB;
      held_exp  = 10'h001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 2) begin
            in_valid = 1'b1;
            in_data  = 32'h7F80_0000;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_mant", out_mant, held_mant);
         chk("bp_exp", out_exp, held_exp);
         chk("bp_flags", flags, 5'b00000);
      end
      xfer();
      chk("bp_post_ready", in_ready, 1'b1);
      chk("bp_post_valid", out_valid, 1'b0);
      chk("bp_post_mant_kept", out_mant, held_mant);

      // reset in the middle of normalization
      accept(32'h0000_0001);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", out_valid, 1'b0);
      chk("mrst_mant", out_mant, 24'h000000);
      chk("mrst_exp", out_exp, 10'h000);
      chk("mrst_flags", flags, 5'b00000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mrst_in_ready", in_ready, 1'b1);
      stale = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) stale++;
      end
      chk("mrst_no_stale", stale, 0);
      chk("mrst_idle_ready", in_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
